wb_ram_arbiter: RTL and testbench
=================================

Name: wb_ram_arbiter

Overview:
Two-master to one-slave Wishbone classic arbiter sitting directly upstream of the on-chip RAM wrapper.
- Master 0 is the CPU instruction bus; master 1 is the CPU data bus (or a loader).
- The slave port drives the RAM wrapper, which acks exactly one cycle after any sampled cyc&stb.
- The arbiter issues exactly one slave strobe per granted transaction, waits for the ack, and returns ack plus read data to the granted master only.
- Round-robin arbitration between the two masters.

Parameters:
ADR_W, 10, word-address width passed through to the slave (DEPTH 1024 words).

Ports:
clk_i  in  1  clock
rst_in  in  1  reset, asynchronous, active-low
m0_cyc_i  in  1  master 0 cycle
m0_stb_i  in  1  master 0 strobe
m0_we_i  in  1  master 0 write enable
m0_sel_i  in  4  master 0 byte selects
m0_adr_i  in  ADR_W  master 0 word address
m0_dat_i  in  32  master 0 write data
m0_ack_o  out  1  master 0 ack
m0_dat_o  out  32  master 0 read data
m1_*  same set as m0_*, for master 1
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_we_o  out  1  slave write enable
s_sel_o  out  4  slave byte selects
s_adr_o  out  ADR_W  slave word address
s_dat_o  out  32  slave write data
s_ack_i  in  1  slave ack
s_dat_i  in  32  slave read data

Behaviour:
- Request: mN_req = mN_cyc_i & mN_stb_i.
- FSM states: IDLE, REQ, WAIT. Registers: state, gnt (granted master), last (last served master).
- Reset (rst_in=0, async): state=IDLE, gnt=0, last=1, so master 0 wins the first tie.
  - All outputs combinational from the registers: s_cyc_o=0, s_stb_o=0, m0_ack_o=0, m1_ack_o=0.
- IDLE:
  - No request: stay in IDLE.
  - One request: gnt<=that master, go to REQ.
  - Both request: gnt<=~last, go to REQ.
  - s_cyc_o=0, s_stb_o=0.
- REQ:
  - s_cyc_o=1, s_stb_o=1 for exactly one cycle.
  - s_we/sel/adr/dat muxed from the gnt master.
  - If the gnt master's cyc_i=0 (abort): s_cyc_o=s_stb_o=0 and go to IDLE; no slave access occurs.
  - Otherwise go to WAIT.
- WAIT:
  - s_cyc_o=1, s_stb_o=0; s_adr/we/sel/dat stay muxed from gnt (the RAM bank-select read mux depends on the live address).
  - On s_ack_i: m{gnt}_ack_o=s_ack_i (combinational), last<=gnt, go to IDLE.
  - If the gnt master's cyc_i=0 before the ack: go to IDLE, no ack forwarded.
- Read data: m0_dat_o = m1_dat_o = s_dat_i at all times. Only the ack qualifies the data.
- The non-granted master's ack is always 0. Any s_ack_i outside WAIT is ignored.
- Latency: master strobe at cycle 0 (IDLE) → slave strobe at cycle 1 → slave ack and master ack at cycle 2. Sustained throughput is 1 transaction per 3 cycles.
- Masters must hold adr/we/sel/dat stable until ack (Wishbone classic). The arbiter does not latch them.
- Back-to-back: a master still asserting a request in the IDLE cycle after its ack is treated as a new request and arbitrated normally. Under contention this alternates grants.
- Reset mid-transaction: returns to IDLE immediately. No ack is forwarded afterwards, even if the slave acks.

Test Plan:
- Single read, m0 only, adr=0x005, RAM word 0xDEADBEEF: s_stb_o high at cycle 1 only → m0_ack_o=1 at cycle 2 with m0_dat_o=0xDEADBEEF; m1_ack_o stays 0.
- Write then read, m1 writes 0x12345678 to adr=0x201 with sel=4'b0011, then reads it back: read data=0x????5678 (upper bytes unchanged); s_adr_o=0x201 held through WAIT.
- Contention: m0 and m1 request continuously from reset → grants m0,m1,m0,m1; one ack every 3 cycles; acks never overlap.
- Abort: m1 drops cyc in the REQ cycle → s_stb_o=0 that cycle, state returns to IDLE, no ack to m1. A following m0 request completes normally.
- Async reset asserted in WAIT → outputs go to 0 immediately without a clock edge. The following slave ack is not forwarded. After release, the first tie grants m0.

Source files
------------

// File: rtl/wb_ram_arbiter.sv
// Two-master to one-slave Wishbone classic arbiter with round-robin grant.
// One slave strobe per granted transaction; ack and data are returned only to the granted master.
module wb_ram_arbiter #(
  parameter int ADR_W = 10
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [3:0]       m0_sel_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [31:0]      m0_dat_i,
  output logic             m0_ack_o,
  output logic [31:0]      m0_dat_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [3:0]       m1_sel_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [31:0]      m1_dat_i,
  output logic             m1_ack_o,
  output logic [31:0]      m1_dat_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [3:0]       s_sel_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [31:0]      s_dat_o,
  input  logic             s_ack_i,
  input  logic [31:0]      s_dat_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state_r, state_s;
  logic   gnt_r, gnt_s;
  logic   last_r, last_s;
  logic   m0_req_s, m1_req_s, gnt_cyc_s;

  assign m0_req_s  = m0_cyc_i & m0_stb_i;
  assign m1_req_s  = m1_cyc_i & m1_stb_i;
  assign gnt_cyc_s = gnt_r ? m1_cyc_i : m0_cyc_i;

  // State, grant and last-served registers; last starts at 1 so master 0 wins the first tie
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_r <= IDLE;
      gnt_r   <= 1'b0;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      last_r  <= last_s;
    end
  end

  // Next-state logic and round-robin grant selection
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    last_s  = last_r;
    case (state_r)
      IDLE: begin
        if (m0_req_s && m1_req_s) begin
          gnt_s   = ~last_r;
          state_s = REQ;
        end else if (m0_req_s) begin
          gnt_s   = 1'b0;
          state_s = REQ;
        end else if (m1_req_s) begin
          gnt_s   = 1'b1;
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (gnt_cyc_s) begin
          state_s = WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        // A master dropping cyc abandons the transfer; the slave's late ack is then ignored
        if (!gnt_cyc_s) begin
          state_s = IDLE;
        end else if (s_ack_i) begin
          last_s  = gnt_r;
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Slave cycle/strobe and per-master ack, decoded from the current state
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    case (state_r)
      IDLE: begin
        s_cyc_o = 1'b0;
      end
      REQ: begin
        s_cyc_o = gnt_cyc_s;
        s_stb_o = gnt_cyc_s;
      end
      WAIT: begin
        s_cyc_o = 1'b1;
        if (gnt_cyc_s) begin
          m0_ack_o = s_ack_i & ~gnt_r;
          m1_ack_o = s_ack_i & gnt_r;
        end else begin
          m0_ack_o = 1'b0;
          m1_ack_o = 1'b0;
        end
      end
      default: begin
        s_cyc_o = 1'b0;
      end
    endcase
  end

  // Slave request fields follow the granted master live; the RAM read mux needs the live address
  assign s_we_o   = gnt_r ? m1_we_i  : m0_we_i;
  assign s_sel_o  = gnt_r ? m1_sel_i : m0_sel_i;
  assign s_adr_o  = gnt_r ? m1_adr_i : m0_adr_i;
  assign s_dat_o  = gnt_r ? m1_dat_i : m0_dat_i;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Bench for wb_ram_arbiter: RAM slave model, transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_wb_ram_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_in;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [9:0]  m0_adr_i;
  logic [31:0] m0_dat_i;
  logic        m0_ack_o;
  logic [31:0] m0_dat_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [9:0]  m1_adr_i;
  logic [31:0] m1_dat_i;
  logic        m1_ack_o;
  logic [31:0] m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [9:0]  s_adr_o;
  logic [31:0] s_dat_o;
  logic        s_ack_i = 1'b0;
  logic [31:0] s_dat_i = 32'h0;

  int n_tests = 0;
  int n_fail  = 0;

  wb_ram_arbiter #(.ADR_W(10)) dut (
    .clk_i(clk_i), .rst_in(rst_in),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM slave: acks one cycle after any sampled cyc&stb, byte-lane writes, preset contents
  logic [31:0]   mem [0:1023];
  logic [1023:0] wr_v = '0;

  function automatic logic [31:0] preset(input logic [9:0] a);
    if (a == 10'h005)      return 32'hDEADBEEF;
    else if (a == 10'h201) return 32'hAABBCCDD;
    else                   return {22'h0, a};
  endfunction

  always @(posedge clk_i) begin
    s_ack_i <= s_cyc_o & s_stb_o;
    if (s_cyc_o && s_stb_o) begin
      s_dat_i <= wr_v[s_adr_o] ? mem[s_adr_o] : preset(s_adr_o);
      if (s_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (s_sel_o[b]) mem[s_adr_o][8*b +: 8] <= s_dat_o[8*b +: 8];
          else            mem[s_adr_o][8*b +: 8] <= (wr_v[s_adr_o] ? mem[s_adr_o][8*b +: 8]
                                                                    : preset(s_adr_o) >> (8*b));
        end
        wr_v[s_adr_o] <= 1'b1;
      end
    end
  end

  // Reference model: a transaction starts in a cycle where none is open and a request is present,
  // strobes the slave on the next cycle and is acked on the one after.
  int   cyc_n = 0;
  bit   act_t = 1'b0;
  int   t_m, t_start, ph;
  bit   mlast = 1'b1;
  logic g_cyc, e_cyc, e_stb, e_a0, e_a1, r0, r1;

  always @(posedge clk_i) cyc_n <= cyc_n + 1;

  always @(negedge clk_i) begin
    chk("m0_dat_follows_slave", m0_dat_o, s_dat_i);
    chk("m1_dat_follows_slave", m1_dat_o, s_dat_i);
    if (!rst_in) begin
      act_t = 1'b0;
      mlast = 1'b1;
      chk("rst_s_cyc", {31'h0, s_cyc_o}, 32'h0);
      chk("rst_s_stb", {31'h0, s_stb_o}, 32'h0);
      chk("rst_acks", {30'h0, m1_ack_o, m0_ack_o}, 32'h0);
    end else if (act_t) begin
      ph    = cyc_n - t_start;
      g_cyc = (t_m == 1) ? m1_cyc_i : m0_cyc_i;
      e_cyc = (ph >= 2) || g_cyc;
      e_stb = (ph == 1) && g_cyc;
      e_a0  = (ph >= 2) && g_cyc && s_ack_i && (t_m == 0);
      e_a1  = (ph >= 2) && g_cyc && s_ack_i && (t_m == 1);
      chk("s_cyc", {31'h0, s_cyc_o}, {31'h0, e_cyc});
      chk("s_stb", {31'h0, s_stb_o}, {31'h0, e_stb});
      chk("m0_ack", {31'h0, m0_ack_o}, {31'h0, e_a0});
      chk("m1_ack", {31'h0, m1_ack_o}, {31'h0, e_a1});
      if (e_cyc) begin
        chk("s_adr", {22'h0, s_adr_o}, {22'h0, (t_m == 1) ? m1_adr_i : m0_adr_i});
        chk("s_we",  {31'h0, s_we_o},  {31'h0, (t_m == 1) ? m1_we_i : m0_we_i});
        chk("s_sel", {28'h0, s_sel_o}, {28'h0, (t_m == 1) ? m1_sel_i : m0_sel_i});
        chk("s_dat", s_dat_o, (t_m == 1) ? m1_dat_i : m0_dat_i);
      end
      if (ph == 2 && g_cyc) chk("slave_acked", {31'h0, s_ack_i}, 32'h1);
      if (ph == 1 && !g_cyc) begin
        act_t = 1'b0;
      end else if (ph >= 2 && (!g_cyc || s_ack_i)) begin
        if (g_cyc) mlast = (t_m == 1);
        act_t = 1'b0;
      end
    end else begin
      chk("idle_s_cyc", {31'h0, s_cyc_o}, 32'h0);
      chk("idle_s_stb", {31'h0, s_stb_o}, 32'h0);
      chk("idle_acks", {30'h0, m1_ack_o, m0_ack_o}, 32'h0);
      r0 = m0_cyc_i & m0_stb_i;
      r1 = m1_cyc_i & m1_stb_i;
      if (r0 || r1) begin
        t_m     = (r0 && r1) ? (mlast ? 0 : 1) : (r1 ? 1 : 0);
        t_start = cyc_n;
        act_t   = 1'b1;
      end
    end
  end

  task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [3:0] sel, input logic [9:0] adr, input logic [31:0] dat);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_sel_i = sel; m0_adr_i = adr; m0_dat_i = dat;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_sel_i = sel; m1_adr_i = adr; m1_dat_i = dat;
    end
  endtask

  // Called just after a rising edge; k counts cycles from the request cycle
  task automatic run_xfer(input int m, input logic we, input logic [3:0] sel, input logic [9:0] adr,
                          input logic [31:0] dat, output logic [31:0] rd, output int ack_k,
                          output int stb_n, output logic [9:0] adr_ack);
    set_m(m, 1'b1, 1'b1, we, sel, adr, dat);
    ack_k = -1; stb_n = 0; rd = 32'h0; adr_ack = 10'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      if (s_stb_o) stb_n++;
      if ((m == 0) ? m0_ack_o : m1_ack_o) begin
        ack_k   = k;
        rd      = (m == 0) ? m0_dat_o : m1_dat_o;
        adr_ack = s_adr_o;
        break;
      end
    end
    @(posedge clk_i); #1;
    set_m(m, 1'b0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
  endtask

  logic [31:0] rd;
  logic [9:0]  adr_ack;
  int          ack_k, stb_n, n_ack, overlap, seen;
  int          ack_at [4];
  int          ack_who [4];

  initial begin
    rst_in = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_s_cyc", {31'h0, s_cyc_o}, 32'h0);
    chk("reset_acks", {30'h0, m1_ack_o, m0_ack_o}, 32'h0);
    #1 rst_in = 1'b1;
    @(posedge clk_i); #1;

    // Single read by m0
    run_xfer(0, 1'b0, 4'hF, 10'h005, 32'h0, rd, ack_k, stb_n, adr_ack);
    chk("rd0_latency", ack_k, 32'd2);
    chk("rd0_one_strobe", stb_n, 32'd1);
    chk("rd0_data", rd, 32'hDEADBEEF);

    // m1 partial write then read-back
    run_xfer(1, 1'b1, 4'b0011, 10'h201, 32'h12345678, rd, ack_k, stb_n, adr_ack);
    chk("wr1_latency", ack_k, 32'd2);
    chk("wr1_adr_in_wait", {22'h0, adr_ack}, 32'h201);
    run_xfer(1, 1'b0, 4'hF, 10'h201, 32'h0, rd, ack_k, stb_n, adr_ack);
    chk("rd1_data", rd, 32'hAABB5678);

    // Contention: m1 was served last, so grants go m0,m1,m0,m1 on every third cycle
    for (int i = 0; i < 4; i++) begin ack_at[i] = -1; ack_who[i] = -1; end
    set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 10'h005, 32'h0);
    set_m(1, 1'b1, 1'b1, 1'b0, 4'hF, 10'h201, 32'h0);
    n_ack = 0; overlap = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      if (m0_ack_o && m1_ack_o) overlap++;
      if (m0_ack_o || m1_ack_o) begin
        if (n_ack < 4) begin ack_at[n_ack] = k; ack_who[n_ack] = m1_ack_o ? 1 : 0; end
        n_ack++;
      end
    end
    @(posedge clk_i); #1;
    set_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    chk("cont_ack_count", n_ack, 32'd4);
    chk("cont_overlap", overlap, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("cont_ack_cycle", ack_at[i], 2 + 3 * i);
      chk("cont_ack_master", ack_who[i], i % 2);
    end

    // Abort: m1 drops cyc during its strobe cycle
    set_m(1, 1'b1, 1'b1, 1'b0, 4'hF, 10'h201, 32'h0);
    @(posedge clk_i); #1;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    #1;
    chk("abort_stb", {31'h0, s_stb_o}, 32'h0);
    chk("abort_cyc", {31'h0, s_cyc_o}, 32'h0);
    seen = 0;
    repeat (4) begin @(negedge clk_i); if (m1_ack_o) seen++; end
    chk("abort_no_ack", seen, 32'd0);
    @(posedge clk_i); #1;
    run_xfer(0, 1'b0, 4'hF, 10'h005, 32'h0, rd, ack_k, stb_n, adr_ack);
    chk("after_abort_latency", ack_k, 32'd2);
    chk("after_abort_data", rd, 32'hDEADBEEF);

    // Async reset while m1 is waiting on its ack
    set_m(1, 1'b1, 1'b1, 1'b0, 4'hF, 10'h201, 32'h0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_in = 1'b0;
    #1;
    chk("rst_wait_slave_ack_present", {31'h0, s_ack_i}, 32'h1);
    chk("rst_wait_s_cyc", {31'h0, s_cyc_o}, 32'h0);
    chk("rst_wait_m1_ack", {31'h0, m1_ack_o}, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    repeat (2) @(posedge clk_i);
    #2 rst_in = 1'b1;
    set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 10'h005, 32'h0);
    set_m(1, 1'b1, 1'b1, 1'b0, 4'hF, 10'h201, 32'h0);
    ack_k = -1; seen = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      if (m0_ack_o || m1_ack_o) begin ack_k = k; seen = m1_ack_o ? 1 : 0; break; end
    end
    chk("post_rst_first_grant", seen, 32'd0);
    chk("post_rst_latency", ack_k, 32'd2);
    @(posedge clk_i); #1;
    set_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    repeat (3) @(posedge clk_i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=50000", $time);
    $fatal(1);
  end

endmodule
